// File: rtl/rx_capture_ctrl.sv
// ---------------------------------------------------------------------------
// rx_capture_ctrl
//
// Capture sequencer for the RGMII receive debug path. Every clk_i the 5-bit
// sample {rx_d[3:0], rx_dv} can be written into a DEPTH-entry ring buffer.
// An arm request starts a capture. The capture first fills a pre-trigger
// window of PRE_DEPTH samples, then waits for a programmable trigger while
// the ring keeps overwriting its oldest entries. It then fills the
// post-trigger part of the window. Once the window is complete, the host
// drains it oldest-first through a one-cycle-latency read port.
//
// Ports
//   clk_i        rising-edge clock for all logic
//   rst_i        synchronous active-high reset
//   data_i       sample {rx_d[3:0], rx_dv}; bit 0 is dv
//   arm_i        single-cycle capture start (IDLE or DONE only)
//   abort_i      single-cycle cancel, returns to IDLE
//   trig_mode_i  00 dv rise, 01 dv fall, 10 masked match, 11 immediate
//   trig_val_i   match value for masked mode
//   trig_mask_i  match mask for masked mode (1 = bit compared)
//   state_o      IDLE=0 PRE=1 WAIT=2 POST=3 DONE=4
//   busy_o       capture in progress (PRE, WAIT, POST)
//   done_o       window complete, readout available
//   trig_addr_o  buffer address holding the trigger sample
//   rd_en_i      readout request, one sample per asserted cycle in DONE
//   rd_data_o    readout sample, valid one cycle after rd_en_i
//   rd_valid_o   rd_data_o carries a sample this cycle
//   rd_last_o    marks the DEPTH-th (final) readout sample
//
// PRE_DEPTH must lie in 1 .. DEPTH-2 so that both the pre-trigger and the
// post-trigger parts of the window are non-empty.
// ---------------------------------------------------------------------------
module rx_capture_ctrl #(
  parameter int AW        = 9,
  parameter int PRE_DEPTH = 64
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [4:0]    data_i,
  input  logic          arm_i,
  input  logic          abort_i,
  input  logic [1:0]    trig_mode_i,
  input  logic [4:0]    trig_val_i,
  input  logic [4:0]    trig_mask_i,
  output logic [2:0]    state_o,
  output logic          busy_o,
  output logic          done_o,
  output logic [AW-1:0] trig_addr_o,
  input  logic          rd_en_i,
  output logic [4:0]    rd_data_o,
  output logic          rd_valid_o,
  output logic          rd_last_o
);

  localparam int DEPTH = 2**AW;

  // cnt carries one extra bit so the pre and post counts always fit.
  localparam logic [AW:0]   PRE_LAST  = (AW+1)'(PRE_DEPTH - 1);
  localparam logic [AW:0]   POST_LAST = (AW+1)'(DEPTH - PRE_DEPTH - 1);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [AW-1:0] RD_LAST   = AW'(DEPTH - 1);
  localparam logic [AW-1:0] PRE_OFS   = AW'(PRE_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_WAIT = 3'd2,
    ST_POST = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  state_t        state;
  state_t        state_next;

  logic [4:0]    mem [DEPTH];

  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   cnt;
  logic [AW-1:0] rd_cnt;
  logic [AW-1:0] trig_addr;

  logic          prev_dv;
  logic [1:0]    mode;
  logic [4:0]    match_val;
  logic [4:0]    match_mask;

  logic [4:0]    rd_data;
  logic          rd_valid;
  logic          rd_last;

  logic          trig_cond;
  logic          capture_en;
  logic          start;
  logic          trig_take;
  logic          window_full;
  logic          rd_issue;

  // Trigger evaluation uses the settings latched when the capture was armed,
  // so the host may change the trig_* inputs while a capture is running.
  always_comb begin
    trig_cond = 1'b0;
    case (mode)
      2'b00:   trig_cond = !prev_dv && data_i[0];
      2'b01:   trig_cond = prev_dv && !data_i[0];
      2'b10:   trig_cond = ((data_i ^ match_val) & match_mask) == 5'd0;
      default: trig_cond = 1'b1;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and datapath strobes. Abort overrides everything done by the
  // case statement. This also kills a read or an arm issued in the same
  // cycle, so nothing is left outstanding.
  always_comb begin
    state_next  = state;
    capture_en  = 1'b0;
    start       = 1'b0;
    trig_take   = 1'b0;
    window_full = 1'b0;
    rd_issue    = 1'b0;

    case (state)
      ST_IDLE: begin
        if (arm_i) begin
          start      = 1'b1;
          state_next = ST_PRE;
        end
      end

      // The trigger is deliberately not looked at here, even on the last
      // pre-trigger cycle.
      ST_PRE: begin
        capture_en = 1'b1;
        if (cnt == PRE_LAST) begin
          state_next = ST_WAIT;
        end
      end

      ST_WAIT: begin
        capture_en = 1'b1;
        if (trig_cond) begin
          trig_take  = 1'b1;
          state_next = ST_POST;
        end
      end

      // cnt already includes the trigger sample. The write in this cycle is
      // the final one of the window when cnt is one short of the post length.
      ST_POST: begin
        capture_en = 1'b1;
        if (cnt == POST_LAST) begin
          window_full = 1'b1;
          state_next  = ST_DONE;
        end
      end

      // Re-arming abandons the remaining readout. The read issued together
      // with the final sample still delivers its data in IDLE.
      ST_DONE: begin
        if (arm_i) begin
          start      = 1'b1;
          state_next = ST_PRE;
        end else if (rd_en_i) begin
          rd_issue = 1'b1;
          if (rd_cnt == RD_LAST) begin
            state_next = ST_IDLE;
          end
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase

    if (abort_i) begin
      state_next  = ST_IDLE;
      capture_en  = 1'b0;
      start       = 1'b0;
      trig_take   = 1'b0;
      window_full = 1'b0;
      rd_issue    = 1'b0;
    end
  end

  // Sample buffer write port. Contents are intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (capture_en && !rst_i) begin
      mem[wp] <= data_i;
    end
  end

  // Pointers, counters, latched trigger settings and the registered read
  // port. cnt is frozen in WAIT so a long wait cannot wrap it. It restarts
  // at one on the trigger sample.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wp         <= '0;
      rp         <= '0;
      cnt        <= '0;
      rd_cnt     <= '0;
      trig_addr  <= '0;
      prev_dv    <= 1'b0;
      mode       <= 2'b00;
      match_val  <= 5'd0;
      match_mask <= 5'd0;
      rd_data    <= 5'd0;
      rd_valid   <= 1'b0;
      rd_last    <= 1'b0;
    end else begin
      prev_dv  <= data_i[0];
      rd_valid <= rd_issue;
      rd_last  <= rd_issue && (rd_cnt == RD_LAST);

      if (start) begin
        wp         <= '0;
        cnt        <= '0;
        mode       <= trig_mode_i;
        match_val  <= trig_val_i;
        match_mask <= trig_mask_i;
      end else if (capture_en) begin
        wp <= wp + PTR_ONE;
        if (trig_take) begin
          trig_addr <= wp;
          cnt       <= CNT_ONE;
        end else if (state != ST_WAIT) begin
          cnt <= cnt + CNT_ONE;
        end
      end

      // The oldest sample of the window sits PRE_DEPTH entries before the
      // trigger. The subtraction wraps naturally with the ring.
      if (window_full) begin
        rp     <= trig_addr - PRE_OFS;
        rd_cnt <= '0;
      end else if (rd_issue) begin
        rp      <= rp + PTR_ONE;
        rd_cnt  <= rd_cnt + PTR_ONE;
        rd_data <= mem[rp];
      end
    end
  end

  assign state_o     = state;
  assign busy_o      = (state == ST_PRE) || (state == ST_WAIT) || (state == ST_POST);
  assign done_o      = (state == ST_DONE);
  assign trig_addr_o = trig_addr;
  assign rd_data_o   = rd_data;
  assign rd_valid_o  = rd_valid;
  assign rd_last_o   = rd_last;

endmodule

// File: tb/tb_rx_capture_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rx_capture_ctrl
//
// Bench for rx_capture_ctrl with AW=4 (DEPTH=16) and PRE_DEPTH=4. A
// reference model runs alongside the DUT. The model keeps every captured
// sample in a plain log and takes the readout window from that log around
// the trigger index. A vector table covers the immediate-trigger walk.
// Hand-written sequences cover the multi-cycle corner cases. A randomized
// phase follows.
// ---------------------------------------------------------------------------
module tb_rx_capture_ctrl;

  localparam int AW        = 4;
  localparam int DEPTH     = 16;
  localparam int PRE_DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [4:0]    data = 5'd0;
  logic          arm = 1'b0;
  logic          abort = 1'b0;
  logic [1:0]    trig_mode = 2'b00;
  logic [4:0]    trig_val = 5'd0;
  logic [4:0]    trig_mask = 5'd0;
  logic          rd_en = 1'b0;
  logic [2:0]    state;
  logic          busy;
  logic          done;
  logic [AW-1:0] trig_addr;
  logic [4:0]    rd_data;
  logic          rd_valid;
  logic          rd_last;

  int checks = 0;
  int errors = 0;

  rx_capture_ctrl #(.AW(AW), .PRE_DEPTH(PRE_DEPTH)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .data_i      (data),
    .arm_i       (arm),
    .abort_i     (abort),
    .trig_mode_i (trig_mode),
    .trig_val_i  (trig_val),
    .trig_mask_i (trig_mask),
    .state_o     (state),
    .busy_o      (busy),
    .done_o      (done),
    .trig_addr_o (trig_addr),
    .rd_en_i     (rd_en),
    .rd_data_o   (rd_data),
    .rd_valid_o  (rd_valid),
    .rd_last_o   (rd_last)
  );

  always #5 clk = ~clk;

  // Reference model state.
  int         m_state = 0;
  logic       m_prev_dv = 1'b0;
  logic [1:0] m_mode = 2'b00;
  logic [4:0] m_val = 5'd0;
  logic [4:0] m_mask = 5'd0;
  logic [4:0] m_log[$];
  logic [4:0] m_win[$];
  int         m_trig_idx = 0;
  int         m_rd_i = 0;
  logic [3:0] m_trig_addr = 4'd0;
  logic       m_rd_valid = 1'b0;
  logic       m_rd_last = 1'b0;
  logic [4:0] m_rd_data = 5'd0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_start();
    m_mode  = trig_mode;
    m_val   = trig_val;
    m_mask  = trig_mask;
    m_log.delete();
    m_state = 1;
  endtask

  // Advances the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    bit trig;
    case (m_mode)
      2'b00:   trig = !m_prev_dv && data[0];
      2'b01:   trig = m_prev_dv && !data[0];
      2'b10:   trig = ((data ^ m_val) & m_mask) == 5'd0;
      default: trig = 1'b1;
    endcase
    if (rst) begin
      m_state = 0; m_prev_dv = 1'b0; m_mode = 2'b00; m_val = 5'd0; m_mask = 5'd0;
      m_log.delete(); m_win.delete();
      m_trig_addr = 4'd0; m_rd_valid = 1'b0; m_rd_last = 1'b0; m_rd_data = 5'd0;
      return;
    end
    m_rd_valid = 1'b0;
    m_rd_last  = 1'b0;
    if (abort) begin
      m_state = 0;
    end else begin
      case (m_state)
        0: if (arm) model_start();
        1: begin
          m_log.push_back(data);
          if (m_log.size() == PRE_DEPTH) m_state = 2;
        end
        2: begin
          m_log.push_back(data);
          if (trig) begin
            m_trig_idx  = m_log.size() - 1;
            m_trig_addr = 4'(m_trig_idx % DEPTH);
            m_state     = 3;
          end
        end
        3: begin
          m_log.push_back(data);
          if (m_log.size() - m_trig_idx == DEPTH - PRE_DEPTH) begin
            m_win.delete();
            for (int i = 0; i < DEPTH; i++) m_win.push_back(m_log[m_trig_idx - PRE_DEPTH + i]);
            m_rd_i  = 0;
            m_state = 4;
          end
        end
        default: begin
          if (arm) begin
            model_start();
          end else if (rd_en) begin
            m_rd_valid = 1'b1;
            m_rd_data  = m_win[m_rd_i];
            m_rd_last  = (m_rd_i == DEPTH - 1);
            m_rd_i++;
            if (m_rd_i == DEPTH) m_state = 0;
          end
        end
      endcase
    end
    m_prev_dv = data[0];
  endtask

  task automatic compare_all();
    check_output("state", 32'(state), 32'(m_state));
    check_output("busy", 32'(busy), 32'(m_state >= 1 && m_state <= 3));
    check_output("done", 32'(done), 32'(m_state == 4));
    check_output("trig_addr", 32'(trig_addr), 32'(m_trig_addr));
    check_output("rd_valid", 32'(rd_valid), 32'(m_rd_valid));
    check_output("rd_last", 32'(rd_last), 32'(m_rd_last));
    check_output("rd_data", 32'(rd_data), 32'(m_rd_data));
  endtask

  // One clock: the model steps on the driven inputs, the DUT takes the edge,
  // and outputs are compared 1 ns after the edge.
  task automatic apply_stimulus();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic hold_cycles(input int n);
    for (int i = 0; i < n; i++) apply_stimulus();
  endtask

  task automatic arm_capture(input logic [1:0] md);
    trig_mode = md;
    arm = 1'b1;
    apply_stimulus();
    arm = 1'b0;
  endtask

  typedef struct {
    logic       arm;
    logic       rd_en;
    logic [4:0] data;
    logic [2:0] exp_state;
    logic       exp_valid;
    logic [4:0] exp_rdata;
    logic       exp_last;
    logic [3:0] exp_taddr;
  } vec_t;

  vec_t vecs[35];

  initial begin
    int rd_seen;
    logic [4:0] probe[3];
    bit         hit[3];

    // Immediate-trigger walk: arm at vector 0, PRE samples 0..3, the trigger
    // sample 4 arrives in WAIT, POST runs to 15, then 16 reads and one idle
    // read request.
    for (int k = 0; k < 35; k++) begin
      vecs[k].arm       = (k == 0);
      vecs[k].rd_en     = (k >= 17 && k <= 32) || (k == 34);
      vecs[k].data      = (k >= 1 && k <= 16) ? 5'(k - 1) : 5'd0;
      vecs[k].exp_state = (k <= 3) ? 3'd1 : (k == 4) ? 3'd2 : (k <= 15) ? 3'd3 :
                          (k <= 31) ? 3'd4 : 3'd0;
      vecs[k].exp_valid = (k >= 17 && k <= 32);
      vecs[k].exp_rdata = (k >= 17 && k <= 32) ? 5'(k - 17) : (k > 32) ? 5'd15 : 5'd0;
      vecs[k].exp_last  = (k == 32);
      vecs[k].exp_taddr = (k >= 5) ? 4'd4 : 4'd0;
    end

    rst = 1'b1;
    hold_cycles(2);
    rst = 1'b0;
    hold_cycles(1);
    check_output("reset_state", 32'(state), 32'd0);
    check_output("reset_rd_valid", 32'(rd_valid), 32'd0);

    // Table-driven immediate trigger.
    trig_mode = 2'b11;
    for (int k = 0; k < 35; k++) begin
      arm   = vecs[k].arm;
      rd_en = vecs[k].rd_en;
      data  = vecs[k].data;
      apply_stimulus();
      check_output($sformatf("vec%0d_state", k), 32'(state), 32'(vecs[k].exp_state));
      check_output($sformatf("vec%0d_valid", k), 32'(rd_valid), 32'(vecs[k].exp_valid));
      check_output($sformatf("vec%0d_rdata", k), 32'(rd_data), 32'(vecs[k].exp_rdata));
      check_output($sformatf("vec%0d_last", k), 32'(rd_last), 32'(vecs[k].exp_last));
      check_output($sformatf("vec%0d_taddr", k), 32'(trig_addr), 32'(vecs[k].exp_taddr));
    end
    arm = 1'b0;
    rd_en = 1'b0;

    // Reset for two cycles in the middle of POST.
    data = 5'd0;
    arm_capture(2'b11);
    hold_cycles(PRE_DEPTH + 1 + 3);
    check_output("pre_reset_in_post", 32'(state), 32'd3);
    rst = 1'b1;
    hold_cycles(2);
    rst = 1'b0;
    hold_cycles(1);
    check_output("post_reset_state", 32'(state), 32'd0);
    check_output("post_reset_busy", 32'(busy), 32'd0);
    check_output("post_reset_done", 32'(done), 32'd0);
    check_output("post_reset_taddr", 32'(trig_addr), 32'd0);
    check_output("post_reset_rdata", 32'(rd_data), 32'd0);
    check_output("post_reset_last", 32'(rd_last), 32'd0);

    // dv rising with a late trigger; the ring wraps several times.
    data = 5'd0;
    arm_capture(2'b00);
    for (int i = 0; i < PRE_DEPTH + 40; i++) begin
      data = {4'($urandom), 1'b0};
      apply_stimulus();
    end
    check_output("late_still_wait", 32'(state), 32'd2);
    data = {4'($urandom), 1'b1};
    apply_stimulus();
    check_output("late_trig_post", 32'(state), 32'd3);
    check_output("late_trig_addr", 32'(trig_addr), 32'((PRE_DEPTH + 40) % DEPTH));
    for (int i = 0; i < DEPTH - PRE_DEPTH - 1; i++) begin
      data = 5'($urandom);
      apply_stimulus();
    end
    check_output("late_done", 32'(done), 32'd1);
    rd_en = 1'b1;
    rd_seen = 0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      if (i == DEPTH) rd_en = 1'b0;
      apply_stimulus();
      if (rd_valid === 1'b1) begin
        if (rd_seen < PRE_DEPTH) check_output($sformatf("late_pre%0d_dv", rd_seen), 32'(rd_data[0]), 32'd0);
        if (rd_seen == PRE_DEPTH) check_output("late_trig_dv", 32'(rd_data[0]), 32'd1);
        rd_seen++;
      end
    end
    check_output("late_read_count", 32'(rd_seen), 32'(DEPTH));

    // A dv rise during PRE is ignored; the next rise in WAIT triggers.
    data = 5'd0;
    arm_capture(2'b00);
    data = 5'd0; hold_cycles(2);
    data = 5'd1; hold_cycles(2);
    data = 5'd1; hold_cycles(2);
    check_output("pre_edge_ignored", 32'(state), 32'd2);
    data = 5'd0; hold_cycles(1);
    check_output("fall_no_trig", 32'(state), 32'd2);
    data = 5'd1; hold_cycles(1);
    check_output("wait_rise_trig", 32'(state), 32'd3);
    check_output("wait_rise_addr", 32'(trig_addr), 32'd7);
    abort = 1'b1; hold_cycles(1); abort = 1'b0;

    // Masked match, with the match inputs scrambled after arming.
    probe[0] = 5'h16; hit[0] = 1'b0;
    probe[1] = 5'h14; hit[1] = 1'b1;
    probe[2] = 5'h15; hit[2] = 1'b1;
    for (int p = 0; p < 3; p++) begin
      trig_val  = 5'b10100;
      trig_mask = 5'b11110;
      data      = 5'd0;
      arm_capture(2'b10);
      trig_val  = 5'h16;
      trig_mask = 5'd0;
      hold_cycles(PRE_DEPTH + 1);
      data = probe[p];
      hold_cycles(1);
      check_output($sformatf("mask_%0h", probe[p]), 32'(state), hit[p] ? 32'd3 : 32'd2);
      abort = 1'b1; hold_cycles(1); abort = 1'b0;
      check_output($sformatf("mask_abort_%0h", probe[p]), 32'(state), 32'd0);
    end

    // Abort in WAIT, arm together with abort, arm in POST and in DONE, reads in IDLE.
    data = 5'd0;
    arm_capture(2'b00);
    hold_cycles(PRE_DEPTH + 2);
    abort = 1'b1; hold_cycles(1); abort = 1'b0;
    check_output("abort_wait_state", 32'(state), 32'd0);
    check_output("abort_wait_done", 32'(done), 32'd0);
    arm = 1'b1; abort = 1'b1; hold_cycles(1); arm = 1'b0; abort = 1'b0;
    check_output("arm_abort_state", 32'(state), 32'd0);
    arm_capture(2'b11);
    hold_cycles(PRE_DEPTH + 1 + 2);
    arm = 1'b1; hold_cycles(1); arm = 1'b0;
    check_output("arm_in_post", 32'(state), 32'd3);
    hold_cycles(DEPTH - PRE_DEPTH - 1 - 3);
    check_output("post_to_done", 32'(state), 32'd4);
    arm = 1'b1; hold_cycles(1); arm = 1'b0;
    check_output("arm_in_done", 32'(state), 32'd1);
    abort = 1'b1; hold_cycles(1); abort = 1'b0;
    rd_en = 1'b1; hold_cycles(3); rd_en = 1'b0;
    check_output("idle_read_valid", 32'(rd_valid), 32'd0);

    // Randomized traffic against the model.
    for (int c = 0; c < 2000; c++) begin
      rst   = ($urandom_range(0, 999) < 3);
      abort = ($urandom_range(0, 99) < 1);
      if (m_state == 0)      arm = ($urandom_range(0, 9) < 3);
      else if (m_state == 4) arm = ($urandom_range(0, 99) < 2);
      else                   arm = ($urandom_range(0, 99) < 3);
      trig_mode = 2'($urandom_range(0, 3));
      trig_val  = 5'($urandom);
      trig_mask = 5'($urandom);
      data      = 5'($urandom);
      rd_en     = ($urandom_range(0, 9) < 7);
      apply_stimulus();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rx_capture_ctrl.md
# rx_capture_ctrl

Capture sequencer for the RGMII receive-side debug datapath: samples the 5-bit `{rx_d[3:0], rx_dv}` bus every `clk_i` into an internal ring buffer. It enforces a pre-trigger window, evaluates a programmable trigger, fills the post-trigger window and then streams the captured window out oldest-first. It sits between the PHY receive pins and the JTAG/host readout logic, replacing free-running probing with an arm/trigger/readout handshake.

## Interface

Parameters:
- `AW`, 9, buffer address width; depth `DEPTH = 2**AW`.
- `PRE_DEPTH`, 64, number of samples kept before the trigger sample; legal range 1 to `DEPTH-2`.

Ports:
- `clk_i`  in  1  PHY receive clock; all logic on its rising edge.
- `rst_i`  in  1  reset, active-high, synchronous. This is decided.
- `data_i`  in  5  sample `{rx_d[3:0], rx_dv}`; bit 0 is `dv`.
- `arm_i`  in  1  single-cycle request to start a capture.
- `abort_i`  in  1  single-cycle cancel of the current capture.
- `trig_mode_i`  in  2  trigger mode:
  - 00: `dv` rising.
  - 01: `dv` falling.
  - 10: masked match.
  - 11: immediate.
- `trig_val_i`  in  5  match value for mode 10.
- `trig_mask_i`  in  5  match mask for mode 10; 1 means the bit is compared.
- `state_o`  out  3  current state: IDLE=0, PRE=1, WAIT=2, POST=3, DONE=4.
- `busy_o`  out  1  high in PRE, WAIT and POST.
- `done_o`  out  1  high in DONE.
- `trig_addr_o`  out  AW  buffer address of the trigger sample.
- `rd_en_i`  in  1  readout request, one sample per asserted cycle.
- `rd_data_o`  out  5  readout sample.
- `rd_valid_o`  out  1  `rd_data_o` is valid this cycle.
- `rd_last_o`  out  1  marks the final (DEPTH-th) readout sample.

## Operation

Buffer and sampling:
- Single-port-write / single-port-read synchronous RAM, DEPTH x 5.
- Write pointer `wp` wraps modulo DEPTH.
- `prev_dv` is a register of `data_i[0]`, updated every cycle in every state.

Trigger:
- 00: `!prev_dv & data_i[0]`.
- 01: `prev_dv & !data_i[0]`.
- 10: `((data_i ^ trig_val_i) & trig_mask_i) == 0`.
- 11: always true.
- Mode, value and mask are latched on the arming cycle.

States:
- IDLE:
  - No writes.
  - `arm_i` sets `wp=0`, `cnt=0` and moves to PRE.
- PRE:
  - Write `data_i` at `wp` every cycle; `wp++`, `cnt++`.
  - After the PRE_DEPTH-th write, move to WAIT.
  - The trigger is ignored in PRE, including on its last cycle.
- WAIT:
  - Write every cycle; the ring overwrites the oldest data.
  - On a trigger cycle, that cycle's sample is written at `wp`, `trig_addr_o <= wp`, `cnt=1`, and the state moves to POST.
- POST:
  - Write every cycle; `cnt++`.
  - When `cnt` reaches `DEPTH-PRE_DEPTH` (trigger sample included), move to DONE.
  - Writes stop.
- DONE:
  - Read pointer `rp` starts at `trig_addr_o - PRE_DEPTH` (mod DEPTH).
  - Each `rd_en_i` cycle reads `rp` and increments it.
  - After the DEPTH-th read issues, return to IDLE; its data is still presented one cycle later.
  - `arm_i` in DONE discards the readout and moves to PRE as it does from IDLE.

Priority: `rst_i` > `abort_i` > `arm_i`.
- `abort_i` in any state moves to IDLE on the next edge and cancels any outstanding read.
- `arm_i` is ignored in PRE, WAIT and POST.

Other rules:
- `rd_en_i` outside DONE is ignored; no RAM read is issued and `rd_valid_o` stays 0.
- Captured window: PRE_DEPTH samples before the trigger, the trigger sample, then `DEPTH-PRE_DEPTH-1` samples after.

## Timing

Reset (`rst_i` high at an edge):
- state=IDLE; `busy_o`, `done_o`, `rd_valid_o`, `rd_last_o`, `trig_addr_o` and `rd_data_o` all 0.
- `prev_dv` is 0; pointers and counters are 0.
- RAM contents are not cleared.
- Reset mid-capture or mid-readout behaves the same.

Latencies:
- `state_o`, `busy_o` and `done_o` are registered and change on the edge after the causing input.
- The trigger decision is combinational on `data_i`; the triggering sample is written in the same cycle.
- Read latency is 1: `rd_en_i` at cycle N gives `rd_valid_o` and `rd_data_o` at N+1.
- `rd_last_o` is high together with `rd_valid_o` for read index DEPTH-1.
- `rd_en_i` held high streams DEPTH samples back-to-back; gaps are allowed.
- Minimum arm-to-DONE time is DEPTH cycles (mode 11).

## Test plan

All scenarios use AW=4 (DEPTH=16) and PRE_DEPTH=4.

- Reset: `rst_i` for 2 cycles mid-POST -> state 0; every output 0 the cycle after release.
- Immediate trigger: mode 11, `data_i` counting 0,1,2…, arm at the sample-0 cycle.
  - PRE lasts 4 cycles; trigger is value 4 at `trig_addr_o`=4.
  - DONE arrives 16 cycles after arm.
  - Readout is 0..15 in order, with `rd_last_o` only on 15.
- `dv` rising, late trigger:
  - Stimulus: mode 00, `dv` low for 40 cycles after PRE, then rising.
  - Readout: exactly 4 samples with `dv`=0, then the trigger sample with `dv`=1, then 11 more.
  - Ring wrap is exercised.
- Edge in PRE ignored: a `dv` rise in PRE cycle 3 produces no trigger; the next rise in WAIT does.
- Masked match: mask=5'b11110, value=5'b10100 -> triggers on `data_i`=5'h14 and 5'h15, not on 5'h16.
- Abort and arm conflicts:
  - `abort_i` in WAIT -> IDLE next cycle, no `done_o`.
  - `arm_i` with `abort_i` -> IDLE.
  - `arm_i` during POST -> ignored.
  - `rd_en_i` in IDLE -> `rd_valid_o` stays 0.
